uart_tx_ctrl: RTL

UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

---
 rtl/uart_tx_ctrl_if.sv | 24 ++
 rtl/uart_tx_ctrl.sv | 93 +++++++++
 2 files changed

// File: rtl/uart_tx_ctrl_if.sv
// Handshake and control bundle between a UART TX controller and its datapath.
interface uart_tx_ctrl_if #(
    parameter int WIDTH = 8
) ();
    localparam int IW = $clog2(WIDTH);

    logic          DATA_VALID;
    logic          PAR_EN;
    logic          load_en;
    logic          ser_en;
    logic [IW-1:0] bit_idx;
    logic [1:0]    mux_sel;
    logic          busy;

    modport master (
        output DATA_VALID, PAR_EN,
        input  load_en, ser_en, bit_idx, mux_sel, busy
    );

    modport slave (
        input  DATA_VALID, PAR_EN,
        output load_en, ser_en, bit_idx, mux_sel, busy
    );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: START, WIDTH data bits LSB first, optional parity, STOP.
module uart_tx_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic           CLK,
    input  logic           RST,
    uart_tx_ctrl_if.slave  bus
);
    localparam int            IW   = $clog2(WIDTH);
    localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          par_en_q, par_en_d;
    logic          load;
    logic          ser;
    logic          busy_c;
    logic [1:0]    mux;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            par_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            par_en_q <= par_en_d;
        end
    end

    always_comb begin
        state_d  = IDLE;
        idx_d    = idx_q;
        par_en_d = par_en_q;
        load     = bus.DATA_VALID && (state_q == IDLE || state_q == STOP);
        mux      = 2'b11;
        ser      = 1'b0;
        busy_c   = 1'b1;

        case (state_q)
            IDLE: begin
                busy_c  = 1'b0;
                state_d = load ? START : IDLE;
            end
            START: begin
                mux     = 2'b00;
                state_d = DATA;
            end
            DATA: begin
                mux = 2'b01;
                ser = 1'b1;
                // bit_idx saturates at LAST so it never wraps while leaving DATA
                if (idx_q == LAST) begin
                    state_d = par_en_q ? PARITY : STOP;
                end else begin
                    state_d = DATA;
                    idx_d   = idx_q + 1'b1;
                end
            end
            PARITY: begin
                mux     = 2'b10;
                state_d = STOP;
            end
            STOP: begin
                state_d = load ? START : IDLE;
            end
            default: begin
                busy_c  = 1'b0;
                state_d = IDLE;
            end
        endcase

        if (load) begin
            idx_d    = '0;
            par_en_d = bus.PAR_EN;
        end
    end

    assign bus.load_en = load;
    assign bus.ser_en  = ser;
    assign bus.bit_idx = idx_q;
    assign bus.mux_sel = mux;
    assign bus.busy    = busy_c;
endmodule
